// File: rtl/linear_params_stream_buffer.sv
// Per-kernel linear parameter store (A, B for AX+B) loaded from an AXI-Stream and
// read as RD_CH_N consecutive kernels per access; kernels past the loaded count read as zero.

module lpsb_bank #(
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++)
        if (be[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[raddr];
endmodule

module linear_params_stream_buffer #(
  parameter int kernal_param_data_width = 16,
  parameter int max_kernal_n            = 512,
  parameter int RD_CH_N                 = 4,
  parameter int simulation_delay        = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_start,
  input  logic [15:0]                          load_kernal_n,
  input  logic                                 load_use_b,
  input  logic [kernal_param_data_width-1:0]   s_axis_data,
  input  logic                                 s_axis_valid,
  input  logic                                 s_axis_last,
  output logic                                 s_axis_ready,
  output logic                                 load_busy,
  output logic                                 load_done,
  output logic                                 load_err,
  input  logic                                 rd_req,
  input  logic [15:0]                          rd_group,
  output logic                                 rd_vld,
  output logic [RD_CH_N*kernal_param_data_width-1:0] rd_dout_a,
  output logic [RD_CH_N*kernal_param_data_width-1:0] rd_dout_b,
  output logic [RD_CH_N-1:0]                   rd_ch_mask
);
  localparam int W     = kernal_param_data_width;
  localparam int DEPTH = max_kernal_n / RD_CH_N;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = (RD_CH_N > 1) ? $clog2(RD_CH_N) : 1;
  localparam int CW    = $clog2(max_kernal_n + 1);
  localparam int BE_N  = 2*W/8;

  // Registered outputs carry no modelled delay; the parameter only keeps the interface.
  if (simulation_delay < 0) begin : g_neg_delay
  end

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, FILL_B, FIN} state_t;

  state_t        state;
  logic [CW-1:0] n_q, kcnt, loaded_cnt, n_clamp;
  logic          use_b;
  logic          beat, last_k, sec_end, sec_err;
  logic          wr_en;
  logic [SW-1:0] wr_sel;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [2*W-1:0]  wr_data;
  logic [BE_N-1:0] wr_be;
  logic [RD_CH_N-1:0][2*W-1:0] bank_rd;
  logic [RD_CH_N-1:0][W-1:0]   a_q, b_q;
  logic [RD_CH_N-1:0] hit;
  logic rd_fire, grp_ok;

  assign load_busy    = (state != IDLE);
  assign s_axis_ready = (state == LOAD_A) || (state == LOAD_B);

  always_comb begin
    n_clamp = CW'(load_kernal_n);
    if (32'(load_kernal_n) > 32'(max_kernal_n)) n_clamp = CW'(max_kernal_n);
  end

  assign beat    = s_axis_ready && s_axis_valid;
  assign last_k  = (kcnt == n_q - 1'b1);
  assign sec_end = beat && (last_k || s_axis_last);
  assign sec_err = beat && (s_axis_last != last_k);

  // Kernel k lives in bank k%RD_CH_N at row k/RD_CH_N; halves written via byte enables.
  assign wr_en   = beat || (state == FILL_B);
  assign wr_sel  = SW'(kcnt % RD_CH_N);
  assign wr_addr = AW'(kcnt / RD_CH_N);
  assign wr_data = (state == FILL_B) ? '0 : {s_axis_data, s_axis_data};
  assign wr_be   = (state == LOAD_A) ? {{(BE_N/2){1'b0}}, {(BE_N/2){1'b1}}}
                                     : {{(BE_N/2){1'b1}}, {(BE_N/2){1'b0}}};

  assign rd_addr = AW'(rd_group);
  assign grp_ok  = 32'(rd_group) < 32'(DEPTH);
  assign rd_fire = rd_req && (state == IDLE);

  for (genvar c = 0; c < RD_CH_N; c++) begin : g_bank
    lpsb_bank #(.DW(2*W), .DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (wr_en && (wr_sel == SW'(c))),
      .be    (wr_be),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (bank_rd[c])
    );
  end

  always_comb begin
    hit = '0;
    for (int c = 0; c < RD_CH_N; c++)
      hit[c] = grp_ok && ((32'(rd_group) * RD_CH_N + c) < 32'(loaded_cnt));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n_q        <= '0;
      kcnt       <= '0;
      use_b      <= 1'b0;
      loaded_cnt <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        IDLE: if (load_start) begin
          if (load_kernal_n == 16'd0) load_err <= 1'b1;
          else begin
            n_q        <= n_clamp;
            use_b      <= load_use_b;
            loaded_cnt <= '0;
            kcnt       <= '0;
            state      <= LOAD_A;
          end
        end
        LOAD_A, LOAD_B: if (beat) begin
          load_err <= sec_err;
          if (sec_end) begin
            kcnt  <= '0;
            state <= (state == LOAD_B) ? FIN : (use_b ? LOAD_B : FILL_B);
          end else kcnt <= kcnt + 1'b1;
        end
        FILL_B: begin
          if (last_k) begin
            kcnt  <= '0;
            state <= FIN;
          end else kcnt <= kcnt + 1'b1;
        end
        FIN: begin
          loaded_cnt <= n_q;
          load_done  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      rd_ch_mask <= '0;
    end else begin
      rd_vld <= rd_fire;
      if (rd_fire) begin
        rd_ch_mask <= hit;
        for (int c = 0; c < RD_CH_N; c++) begin
          a_q[c] <= hit[c] ? bank_rd[c][W-1:0]   : '0;
          b_q[c] <= hit[c] ? bank_rd[c][2*W-1:W] : '0;
        end
      end
    end
  end

  assign rd_dout_a = a_q;
  assign rd_dout_b = b_q;
endmodule
